// File: rtl/multicycle_control_if.sv
// Handshake bundle between the instruction register / datapath and the
// multicycle controller.
//   Inputs to the controller: cond, op, funct, rd (instruction fields held in
//   the IR) and alu_flags ({N,Z,C,V} from the ALU in the current cycle).
//   Outputs from the controller: datapath selects, gated write enables and
//   the current state encoding for debug.
// The slave modport is the controller; the master modport is the
// IR / datapath side.
interface multicycle_control_if;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_control;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic [3:0] state;

  modport slave (
    input  cond, op, funct, rd, alu_flags,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, reg_src, state
  );

  modport master (
    output cond, op, funct, rd, alu_flags,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, reg_src, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control unit for the ARM-subset core (ADD, SUB, AND, ORR, LDR,
// STR, B). A 10-state FSM sequences one shared ALU and one unified memory
// across the cycles of each instruction; it also holds the NZCV flags and the
// condition-pass latch that gates all architectural writes.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; returns the FSM to fetch, clears flags
//   ctrl  - slave side of multicycle_control_if (instruction fields in,
//           datapath selects, write enables and debug state out)
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.slave         ctrl
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9
  } state_e;

  state_e     state_q;
  logic [3:0] flags_q;   // {N,Z,C,V}
  logic       cond_ex_q;

  logic       next_pc, branch, reg_w, mem_w, ir_w, alu_op;
  logic       cond_ex;
  logic       pcs;
  logic [3:0] cmd;
  logic [1:0] flag_w;

  assign cmd = ctrl.funct[4:1];

  // Per-state datapath decode. Write strobes here are ungated.
  always_comb begin
    next_pc              = 1'b0;
    branch               = 1'b0;
    reg_w                = 1'b0;
    mem_w                = 1'b0;
    ir_w                 = 1'b0;
    alu_op               = 1'b0;
    ctrl.adr_src         = 1'b0;
    ctrl.result_src      = 2'b00;
    ctrl.alu_src_a       = 1'b0;
    ctrl.alu_src_b       = 2'b00;
    case (state_q)
      StFetch: begin
        ir_w            = 1'b1;
        next_pc         = 1'b1;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
      end
      StDecode: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
      end
      StMemAdr:   ctrl.alu_src_b = 2'b01;
      StMemRead:  ctrl.adr_src   = 1'b1;
      StMemWb: begin
        ctrl.result_src = 2'b01;
        reg_w           = 1'b1;
      end
      StMemWrite: begin
        ctrl.adr_src = 1'b1;
        mem_w        = 1'b1;
      end
      StExecR:    alu_op = 1'b1;
      StExecI: begin
        ctrl.alu_src_b = 2'b01;
        alu_op         = 1'b1;
      end
      StAluWb:    reg_w = 1'b1;
      StBranch: begin
        ctrl.alu_src_b  = 2'b01;
        ctrl.result_src = 2'b10;
        branch          = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decode and flag-write enables.
  always_comb begin
    ctrl.alu_control = 2'b00;
    if (alu_op) begin
      case (cmd)
        4'b0100: ctrl.alu_control = 2'b00;
        4'b0010: ctrl.alu_control = 2'b01;
        4'b0000: ctrl.alu_control = 2'b10;
        4'b1100: ctrl.alu_control = 2'b11;
        default: ctrl.alu_control = 2'b00;
      endcase
    end
    flag_w[1] = alu_op & ctrl.funct[0];
    flag_w[0] = alu_op & ctrl.funct[0] & ((cmd == 4'b0100) | (cmd == 4'b0010));
  end

  // Condition evaluation against the registered flags.
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    case (ctrl.cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      // Latched once per instruction so its own flag update cannot
      // change whether its writeback happens.
      if (state_q == StDecode) cond_ex_q <= cond_ex;
      if (((state_q == StExecR) || (state_q == StExecI)) && cond_ex_q) begin
        if (flag_w[1]) flags_q[3:2] <= ctrl.alu_flags[3:2];
        if (flag_w[0]) flags_q[1:0] <= ctrl.alu_flags[1:0];
      end
      case (state_q)
        StFetch:    state_q <= StDecode;
        StDecode: begin
          case (ctrl.op)
            2'b01:   state_q <= StMemAdr;
            2'b00:   state_q <= ctrl.funct[5] ? StExecI : StExecR;
            2'b10:   state_q <= StBranch;
            default: state_q <= StFetch;
          endcase
        end
        StMemAdr:   state_q <= ctrl.funct[0] ? StMemRead : StMemWrite;
        StMemRead:  state_q <= StMemWb;
        StExecR:    state_q <= StAluWb;
        StExecI:    state_q <= StAluWb;
        default:    state_q <= StFetch;
      endcase
    end
  end

  assign pcs            = ((ctrl.rd == 4'd15) & reg_w) | branch;
  assign ctrl.pc_write  = ~reset & (next_pc | (pcs & cond_ex_q));
  assign ctrl.reg_write = ~reset & reg_w & cond_ex_q;
  assign ctrl.mem_write = ~reset & mem_w & cond_ex_q;
  assign ctrl.ir_write  = ~reset & ir_w;
  assign ctrl.imm_src   = ctrl.op;
  assign ctrl.reg_src   = {ctrl.op == 2'b01, ctrl.op == 2'b10};
  assign ctrl.state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic clk;
  logic reset;
  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] rs;
    logic       a;
    logic [1:0] b;
    logic [1:0] aluctl;
    logic [1:0] imm;
    logic [1:0] regsrc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  // Monitor: every falling edge the DUT presents one cycle of outputs.
  always @(negedge clk) begin
    exp_t act, e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = '{st: bus.state, pcw: bus.pc_write, adr: bus.adr_src, memw: bus.mem_write,
              irw: bus.ir_write, regw: bus.reg_write, rs: bus.result_src, a: bus.alu_src_a,
              b: bus.alu_src_b, aluctl: bus.alu_control, imm: bus.imm_src,
              regsrc: bus.reg_src};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cyc%0d: got state=%0d pcw=%b memw=%b irw=%b regw=%b all=%h, want state=%0d pcw=%b memw=%b irw=%b regw=%b all=%h",
                 cyc_n, act.st, act.pcw, act.memw, act.irw, act.regw, act,
                 e.st, e.pcw, e.memw, e.irw, e.regw, e);
      end
      cyc_n++;
    end
  end

  task automatic instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                       input logic [3:0] rd, input logic [3:0] fl);
    bus.cond      = cond;
    bus.op        = op;
    bus.funct     = funct;
    bus.rd        = rd;
    bus.alu_flags = fl;
  endtask

  // Push the expected outputs for the current cycle, then advance one edge.
  // Static selects come from the per-state table; write enables and ALU
  // control are hand-supplied by the caller.
  task automatic cyc(input logic [3:0] st, input logic pcw, input logic memw, input logic irw,
                     input logic regw, input logic [1:0] aluctl);
    exp_t e;
    e        = '0;
    e.st     = st;
    e.pcw    = pcw;
    e.memw   = memw;
    e.irw    = irw;
    e.regw   = regw;
    e.aluctl = aluctl;
    e.imm    = bus.op;
    e.regsrc = {bus.op == 2'b01, bus.op == 2'b10};
    case (st)
      4'd0, 4'd1: begin e.a = 1'b1; e.b = 2'b10; e.rs = 2'b10; end
      4'd2:       e.b = 2'b01;
      4'd3:       e.adr = 1'b1;
      4'd4:       e.rs = 2'b01;
      4'd5:       e.adr = 1'b1;
      4'd7:       e.b = 2'b01;
      4'd9:       begin e.b = 2'b01; e.rs = 2'b10; end
      default: ;
    endcase
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    instr(4'b1110, 2'b00, 6'b000000, 4'd0, 4'b0000);
    @(posedge clk);
    #1;
    // Reset held: FETCH decode, all writes forced off.
    cyc(4'd0, 0, 0, 0, 0, 2'b00);
    cyc(4'd0, 0, 0, 0, 0, 2'b00);
    reset = 1'b0;

    // ADDS r5, AL: flags <- 0100 (Z=1)
    instr(4'b1110, 2'b00, 6'b001001, 4'd5, 4'b0100);
    cyc(4'd0, 1, 0, 1, 0, 2'b00);
    cyc(4'd1, 0, 0, 0, 0, 2'b00);
    cyc(4'd6, 0, 0, 0, 0, 2'b00);
    cyc(4'd8, 0, 0, 0, 1, 2'b00);

    // SUBS AL: flags <- 0010 (C=1, Z=0)
    instr(4'b1110, 2'b00, 6'b000101, 4'd1, 4'b0010);
    cyc(4'd0, 1, 0, 1, 0, 2'b00);
    cyc(4'd1, 0, 0, 0, 0, 2'b00);
    cyc(4'd6, 0, 0, 0, 0, 2'b01);
    cyc(4'd8, 0, 0, 0, 1, 2'b00);

    // ADDSEQ with Z=0: no write, flags must stay 0010 despite ALU 1111
    instr(4'b0000, 2'b00, 6'b001001, 4'd4, 4'b1111);
    cyc(4'd0, 1, 0, 1, 0, 2'b00);
    cyc(4'd1, 0, 0, 0, 0, 2'b00);
    cyc(4'd6, 0, 0, 0, 0, 2'b00);
    cyc(4'd8, 0, 0, 0, 0, 2'b00);

    // ORREQ immediate: still fails (Z=0 preserved)
    instr(4'b0000, 2'b00, 6'b111000, 4'd4, 4'b0000);
    cyc(4'd0, 1, 0, 1, 0, 2'b00);
    cyc(4'd1, 0, 0, 0, 0, 2'b00);
    cyc(4'd7, 0, 0, 0, 0, 2'b11);
    cyc(4'd8, 0, 0, 0, 0, 2'b00);

    // ANDCS: C=1 preserved, so it writes
    instr(4'b0010, 2'b00, 6'b000000, 4'd2, 4'b0000);
    cyc(4'd0, 1, 0, 1, 0, 2'b00);
    cyc(4'd1, 0, 0, 0, 0, 2'b00);
    cyc(4'd6, 0, 0, 0, 0, 2'b10);
    cyc(4'd8, 0, 0, 0, 1, 2'b00);

    // LDR r3
    instr(4'b1110, 2'b01, 6'b011001, 4'd3, 4'b0000);
    cyc(4'd0, 1, 0, 1, 0, 2'b00);
    cyc(4'd1, 0, 0, 0, 0, 2'b00);
    cyc(4'd2, 0, 0, 0, 0, 2'b00);
    cyc(4'd3, 0, 0, 0, 0, 2'b00);
    cyc(4'd4, 0, 0, 0, 1, 2'b00);

    // STR: single-cycle MemWrite
    instr(4'b1110, 2'b01, 6'b011000, 4'd3, 4'b0000);
    cyc(4'd0, 1, 0, 1, 0, 2'b00);
    cyc(4'd1, 0, 0, 0, 0, 2'b00);
    cyc(4'd2, 0, 0, 0, 0, 2'b00);
    cyc(4'd5, 0, 1, 0, 0, 2'b00);

    // B AL
    instr(4'b1110, 2'b10, 6'b000000, 4'd0, 4'b0000);
    cyc(4'd0, 1, 0, 1, 0, 2'b00);
    cyc(4'd1, 0, 0, 0, 0, 2'b00);
    cyc(4'd9, 1, 0, 0, 0, 2'b00);

    // BEQ with Z=0: not taken
    instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000);
    cyc(4'd0, 1, 0, 1, 0, 2'b00);
    cyc(4'd1, 0, 0, 0, 0, 2'b00);
    cyc(4'd9, 0, 0, 0, 0, 2'b00);

    // Cond 1111 never executes
    instr(4'b1111, 2'b10, 6'b000000, 4'd0, 4'b0000);
    cyc(4'd0, 1, 0, 1, 0, 2'b00);
    cyc(4'd1, 0, 0, 0, 0, 2'b00);
    cyc(4'd9, 0, 0, 0, 0, 2'b00);

    // ADD pc: writes PC in ALUWB
    instr(4'b1110, 2'b00, 6'b001000, 4'd15, 4'b0000);
    cyc(4'd0, 1, 0, 1, 0, 2'b00);
    cyc(4'd1, 0, 0, 0, 0, 2'b00);
    cyc(4'd6, 0, 0, 0, 0, 2'b00);
    cyc(4'd8, 1, 0, 0, 1, 2'b00);

    // STR aborted by reset in MEMADR: never reaches MEMWRITE
    instr(4'b1110, 2'b01, 6'b011000, 4'd3, 4'b0000);
    cyc(4'd0, 1, 0, 1, 0, 2'b00);
    cyc(4'd1, 0, 0, 0, 0, 2'b00);
    reset = 1'b1;
    cyc(4'd2, 0, 0, 0, 0, 2'b00);
    reset = 1'b0;

    // Op=11 NOP: FETCH, DECODE, back to FETCH with no writes
    instr(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000);
    cyc(4'd0, 1, 0, 1, 0, 2'b00);
    cyc(4'd1, 0, 0, 0, 0, 2'b00);
    cyc(4'd0, 1, 0, 1, 0, 2'b00);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
